dot_deadtime_guard: RTL and testbench
=====================================

# dot_deadtime_guard

Per-driver output-protection stage between `dot_driver` and `HBrigeDriver`. It converts the `data`/`enable` pair into a registered H-bridge command (`drive_en`, `drive_dir`) and guarantees two things: a fixed dead interval with the bridge disabled on every direction reversal, and a hard limit on continuous on-time. One instance per driver, inside the existing per-driver generate loop. Its outputs feed `HBrigeDriver` as `in = drive_dir` and `en_n = ~drive_en`.

## Interface
Parameters:
- `DEAD_CYCLES`, default 4: bridge-off cycles on a reversal. Legal range is 1 to 2^CNT_WIDTH-1.
- `MAX_ON_CYCLES`, default 0: maximum consecutive `drive_en=1` cycles. 0 disables the watchdog.
- `CNT_WIDTH`, default 16: width of the dead counter and the on-time counter.

Ports (all inputs are synchronous to `clock`):
- `clock`, in, 1: system clock. Single clock domain.
- `reset_n`, in, 1: asynchronous reset, active-low.
- `enable`, in, 1: from `dot_driver.enable`. 1 requests drive.
- `data`, in, 1: from `dot_driver.data`. Requested direction: 1 = forward, 0 = reverse.
- `drive_en`, out, 1: bridge enable. Registered.
- `drive_dir`, out, 1: bridge direction. Registered.
- `dead_active`, out, 1: high while in state DEAD.
- `fault`, out, 1: on-time watchdog tripped.

## Operation
States: IDLE, DRIVE, DEAD, FAULT. Encoding is 2 bits, from the package. Evaluate transitions in the order listed; the first match wins.

- IDLE. `drive_en=0`.
  - `enable=1` → DRIVE. Load `drive_dir=data` and clear `on_cnt`.
  - No dead time is applied when starting from rest.
- DRIVE. `drive_en=1`.
  - `enable=0` → IDLE.
  - `data != drive_dir` → DEAD. Load `dead_cnt=DEAD_CYCLES`.
  - `MAX_ON_CYCLES != 0` and `on_cnt == MAX_ON_CYCLES-1` → FAULT.
  - Otherwise increment `on_cnt`.
- DEAD. `drive_en=0`, `dead_active=1`.
  - `enable=0` → IDLE, with no further wait.
  - `dead_cnt == 1` → DRIVE. Load `drive_dir` from the current `data` and clear `on_cnt`.
  - Otherwise decrement `dead_cnt`.
  - If `data` flips back during DEAD, the full interval still completes and the direction is resampled on exit.
- FAULT. `drive_en=0`, `fault=1`.
  - `enable=0` → IDLE, which clears `fault`.
  - While `enable` stays high, the block stays in FAULT with no auto-retry.
- `drive_dir` changes only when entering DRIVE. It holds its value in every other state.
- `on_cnt` saturates. It never wraps, and it is meaningful only in DRIVE.
- Reset mid-operation: all state is cleared immediately and asynchronously. On the first edge after release, IDLE rules apply.

## Timing
- Reset values: state IDLE, `drive_en=0`, `drive_dir=0`, `dead_active=0`, `fault=0`, and both counters 0.
- Latency: an input sampled at edge N is reflected in the outputs after edge N. All outputs are flops; there is no combinational path from input to output.
- Reversal: suppose `data` differs from `drive_dir` at edge N while in DRIVE.
  - `drive_en` is low for exactly DEAD_CYCLES clock cycles, from after edge N to after edge N+DEAD_CYCLES.
  - After edge N+DEAD_CYCLES, `drive_en=1` with the new direction.
- `drive_en` and `drive_dir` never change in the same edge from (1,a) to (1,~a).
- Watchdog: `drive_en` is high for exactly MAX_ON_CYCLES cycles. After the next edge, `drive_en=0` and `fault=1`.
- Simultaneous events: `enable` falling takes priority over a reversal, and a reversal takes priority over a watchdog expiry in the same cycle.

## Structure
- Package `sequencer_pkg` holds:
  - the state typedef/localparams (IDLE=0, DRIVE=1, DEAD=2, FAULT=3);
  - the default `DEAD_CYCLES` constant, shared with `sequencer_chip`.
- Single module with no sub-modules. The two counters are simple enough to stay inline.
- `sequencer_chip` instantiates one per driver inside the generate loop, between `u3` and `u4`.

## Test plan
All scenarios use DEAD_CYCLES=4 and MAX_ON_CYCLES=16 unless a scenario says otherwise.
- Reset: hold `reset_n=0` with `enable=1`, `data=1` → all outputs 0. Release reset → `drive_en=1`, `drive_dir=1` one edge later.
- Reversal: in DRIVE with dir=1, set `data=0` at edge N → `drive_en=0` and `dead_active=1` for 4 cycles. After edge N+4: `drive_en=1`, `drive_dir=0`. The monitor asserts there is never an (1,1)→(1,0) transition.
- Abort and glitch during DEAD:
  - Drop `enable` at dead cycle 2 → IDLE and `dead_active=0` after the next edge.
  - Repeat, but toggle `data` back to 1 mid-DEAD instead → still exactly 4 low cycles, then `drive_dir=1`.
- Watchdog: hold `enable=1`, `data=1` → 16 high cycles, then `fault=1`, `drive_en=0`. Fault is held while `enable=1`; `enable=0` for one cycle clears it. With MAX_ON_CYCLES=0, 1000 cycles produce no fault.
- Priority: in the same cycle `enable` falls and `data` flips → IDLE, not DEAD. Reversal on the final watchdog cycle → DEAD, not FAULT.
- Asynchronous reset in DEAD with `dead_cnt=2` → outputs 0 immediately without a clock edge. After release, the block restarts from IDLE.

Source files
------------

// File: rtl/sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sequencer_pkg
// Description : Shared state encoding and dead-time default for the sequencer
//               output path (dot_deadtime_guard, sequencer_chip).
// Revision    : 1.0 - initial release
// ============================================================================
package sequencer_pkg;

    typedef logic [1:0] guard_state_t;

    localparam guard_state_t c_ST_IDLE  = 2'd0;
    localparam guard_state_t c_ST_DRIVE = 2'd1;
    localparam guard_state_t c_ST_DEAD  = 2'd2;
    localparam guard_state_t c_ST_FAULT = 2'd3;

    localparam int c_DEAD_CYCLES_DEFAULT = 4;

endpackage : sequencer_pkg
`default_nettype wire

// File: rtl/dot_deadtime_guard.sv
`default_nettype none
// ============================================================================
// Module      : dot_deadtime_guard
// Description : Registered H-bridge command with reversal dead time and an
//               optional continuous on-time watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module dot_deadtime_guard
    import sequencer_pkg::*;
#(
    parameter int DEAD_CYCLES   = c_DEAD_CYCLES_DEFAULT,
    parameter int MAX_ON_CYCLES = 0,
    parameter int CNT_WIDTH     = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic enable,
    input  logic data,
    output logic drive_en,
    output logic drive_dir,
    output logic dead_active,
    output logic fault
);

    localparam logic [CNT_WIDTH-1:0] c_DEAD_LOAD = CNT_WIDTH'(DEAD_CYCLES);
    localparam logic [CNT_WIDTH-1:0] c_ON_LAST   = CNT_WIDTH'(MAX_ON_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] c_CNT_SAT   = '1;
    localparam logic                 c_WD_ON     = (MAX_ON_CYCLES != 0);

    guard_state_t           r_state;
    guard_state_t           w_state_next;
    logic [CNT_WIDTH-1:0]   r_dead_cnt;
    logic [CNT_WIDTH-1:0]   r_on_cnt;
    logic                   r_drive_dir;
    logic                   r_drive_en;
    logic                   r_dead_active;
    logic                   r_fault;
    logic                   w_drive_en;
    logic                   w_dead_active;
    logic                   w_fault;

    // State and status flops; status bits are decoded from the next state so
    // every output comes straight from a flop.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= c_ST_IDLE;
            r_drive_en    <= 1'b0;
            r_dead_active <= 1'b0;
            r_fault       <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_drive_en    <= w_drive_en;
            r_dead_active <= w_dead_active;
            r_fault       <= w_fault;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (enable) w_state_next = c_ST_DRIVE;
            end
            c_ST_DRIVE: begin
                if (!enable)                                 w_state_next = c_ST_IDLE;
                else if (data != r_drive_dir)                w_state_next = c_ST_DEAD;
                else if (c_WD_ON && r_on_cnt == c_ON_LAST)   w_state_next = c_ST_FAULT;
            end
            c_ST_DEAD: begin
                if (!enable)                                 w_state_next = c_ST_IDLE;
                else if (r_dead_cnt == CNT_WIDTH'(1))        w_state_next = c_ST_DRIVE;
            end
            default: begin
                if (!enable) w_state_next = c_ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_drive_en    = (w_state_next == c_ST_DRIVE);
        w_dead_active = (w_state_next == c_ST_DEAD);
        w_fault       = (w_state_next == c_ST_FAULT);
    end

    // Direction is only ever loaded on entry to DRIVE, which is what keeps a
    // live bridge from flipping polarity in a single edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_drive_dir <= 1'b0;
            r_dead_cnt  <= '0;
            r_on_cnt    <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_state_next == c_ST_DRIVE) begin
                        r_drive_dir <= data;
                        r_on_cnt    <= '0;
                    end
                end
                c_ST_DRIVE: begin
                    if (w_state_next == c_ST_DEAD) begin
                        r_dead_cnt <= c_DEAD_LOAD;
                    end else if (w_state_next == c_ST_DRIVE && r_on_cnt != c_CNT_SAT) begin
                        r_on_cnt <= r_on_cnt + CNT_WIDTH'(1);
                    end
                end
                c_ST_DEAD: begin
                    if (w_state_next == c_ST_DRIVE) begin
                        r_drive_dir <= data;
                        r_on_cnt    <= '0;
                    end else if (w_state_next == c_ST_DEAD) begin
                        r_dead_cnt <= r_dead_cnt - CNT_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign drive_en    = r_drive_en;
    assign drive_dir   = r_drive_dir;
    assign dead_active = r_dead_active;
    assign fault       = r_fault;

endmodule : dot_deadtime_guard
`default_nettype wire

// File: tb/tb_dot_deadtime_guard.sv
`default_nettype none
// ============================================================================
// Module      : tb_dot_deadtime_guard
// Description : Vector table plus hand sequences for the dead-time guard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dot_deadtime_guard;

    logic clock = 1'b0;
    logic reset_n;
    logic enable;
    logic data;
    logic drive_en, drive_dir, dead_active, fault;

    logic reset2_n;
    logic enable2;
    logic data2;
    logic drive_en2, drive_dir2, dead_active2, fault2;

    int tests = 0;
    int fails = 0;
    int viol  = 0;

    always #5 clock = ~clock;

    dot_deadtime_guard #(.DEAD_CYCLES(4), .MAX_ON_CYCLES(16), .CNT_WIDTH(16)) u_dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .data(data),
        .drive_en(drive_en), .drive_dir(drive_dir),
        .dead_active(dead_active), .fault(fault)
    );

    dot_deadtime_guard #(.DEAD_CYCLES(4), .MAX_ON_CYCLES(0), .CNT_WIDTH(16)) u_dut_nowd (
        .clock(clock), .reset_n(reset2_n), .enable(enable2), .data(data2),
        .drive_en(drive_en2), .drive_dir(drive_dir2),
        .dead_active(dead_active2), .fault(fault2)
    );

    // Output vector order: {drive_en, drive_dir, dead_active, fault}
    typedef struct {
        logic       en;
        logic       d;
        logic [3:0] exp;
    } vec_t;

    typedef struct {
        logic [3:0] exp;
        string      name;
    } sb_t;

    sb_t  sb_q[$];
    vec_t vecs[18];

    // A live bridge must never flip direction in one edge.
    logic prev_en  = 1'b0;
    logic prev_dir = 1'b0;
    always @(posedge clock) begin
        #1;
        if (reset_n && prev_en && drive_en && (prev_dir != drive_dir)) viol <= viol + 1;
        prev_en  <= drive_en && reset_n;
        prev_dir <= drive_dir;
    end

    task automatic check_pop();
        sb_t e;
        logic [3:0] act;
        e   = sb_q.pop_front();
        act = {drive_en, drive_dir, dead_active, fault};
        tests++;
        if (act !== e.exp) begin
            fails++;
            $display("FAIL %s: got {en,dir,dead,fault}=%b required %b at %0t", e.name, act, e.exp, $time);
        end
    endtask

    task automatic step(input logic en, input logic d, input logic [3:0] exp, input string nm);
        enable = en;
        data   = d;
        sb_q.push_back('{exp, nm});
        @(posedge clock);
        #1;
        check_pop();
    endtask

    initial begin
        int bad;

        vecs[0]  = '{1'b1, 1'b1, 4'b1100};   // start from rest, no dead time
        vecs[1]  = '{1'b1, 1'b0, 4'b0110};   // reversal -> DEAD
        vecs[2]  = '{1'b1, 1'b0, 4'b0110};
        vecs[3]  = '{1'b1, 1'b0, 4'b0110};
        vecs[4]  = '{1'b1, 1'b0, 4'b0110};
        vecs[5]  = '{1'b1, 1'b0, 4'b1000};   // exactly 4 low cycles, new dir
        vecs[6]  = '{1'b0, 1'b0, 4'b0000};
        vecs[7]  = '{1'b1, 1'b1, 4'b1100};
        vecs[8]  = '{1'b1, 1'b0, 4'b0110};
        vecs[9]  = '{1'b1, 1'b0, 4'b0110};
        vecs[10] = '{1'b0, 1'b0, 4'b0100};   // abort in DEAD, dir held
        vecs[11] = '{1'b1, 1'b1, 4'b1100};
        vecs[12] = '{1'b1, 1'b0, 4'b0110};
        vecs[13] = '{1'b1, 1'b1, 4'b0110};   // data glitches back
        vecs[14] = '{1'b1, 1'b1, 4'b0110};
        vecs[15] = '{1'b1, 1'b1, 4'b0110};
        vecs[16] = '{1'b1, 1'b1, 4'b1100};   // full interval, resampled dir
        vecs[17] = '{1'b0, 1'b0, 4'b0100};   // enable fall beats reversal

        reset_n  = 1'b0;
        enable   = 1'b1;
        data     = 1'b1;
        reset2_n = 1'b0;
        enable2  = 1'b1;
        data2    = 1'b1;

        repeat (3) @(posedge clock);
        #1;
        sb_q.push_back('{4'b0000, "reset_hold"});
        check_pop();
        reset_n  = 1'b1;
        reset2_n = 1'b1;

        for (int i = 0; i < 18; i++)
            step(vecs[i].en, vecs[i].d, vecs[i].exp, $sformatf("vec%0d", i));

        // Watchdog: 16 high cycles, then latched fault while enable holds.
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 4'b1100, $sformatf("wd_on%0d", i));
        step(1'b1, 1'b1, 4'b0101, "wd_trip");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4'b0101, "wd_hold");
        step(1'b0, 1'b1, 4'b0100, "wd_clear");

        // Reversal on the final watchdog cycle goes to DEAD, not FAULT.
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 4'b1100, $sformatf("pr_on%0d", i));
        step(1'b1, 1'b0, 4'b0110, "pr_rev_dead");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'b0110, "pr_dead");
        step(1'b1, 1'b0, 4'b1000, "pr_drive_rev");
        step(1'b0, 1'b0, 4'b0000, "pr_idle");

        // Asynchronous reset while DEAD with dead_cnt == 2.
        step(1'b1, 1'b1, 4'b1100, "ar_drive");
        step(1'b1, 1'b0, 4'b0110, "ar_dead4");
        step(1'b1, 1'b0, 4'b0110, "ar_dead3");
        step(1'b1, 1'b0, 4'b0110, "ar_dead2");
        #2 reset_n = 1'b0;
        #1;
        sb_q.push_back('{4'b0000, "ar_async_clear"});
        check_pop();
        #1 reset_n = 1'b1;
        step(1'b1, 1'b0, 4'b1000, "ar_restart");
        step(1'b0, 1'b0, 4'b0000, "ar_idle");

        // Watchdog disabled: 1000 cycles of continuous drive, never a fault.
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clock);
            #1;
            if (fault2 !== 1'b0 || drive_en2 !== 1'b1) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL nowd_1000: got %0d bad cycles required 0", bad);
        end

        tests++;
        if (viol != 0) begin
            fails++;
            $display("FAIL no_same_edge_flip: got %0d violations required 0", viol);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_dot_deadtime_guard
`default_nettype wire
